// File: rtl/homo_pkg.sv
// homo_pkg: shared constants and types for the homography responder.
package homo_pkg;
   localparam int H_RES      = 640;
   localparam int V_RES      = 480;
   localparam int ADDR_W     = 19;
   localparam int FRAC_DEF   = 8;
   localparam int COEF_W_DEF = 18;
   typedef struct packed {
      logic [4:0] r;
      logic [5:0] g;
      logic [4:0] b;
   } rgb565_t;
   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic       oob;
   } tag_t;
endpackage

// File: rtl/homo_tag_fifo.sv
// homo_tag_fifo: in-order store of query tags for outstanding frame reads.
module homo_tag_fifo import homo_pkg::*; #(
   parameter int DEPTH = 8,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic        clk_25,
   input  logic        rst,
   input  logic        push,
   input  logic        pop,
   input  tag_t        din,
   output tag_t        dout,
   output logic [AW:0] count,
   output logic        full,
   output logic        empty
);
   tag_t mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic do_push, do_pop;
   assign empty   = count == '0;
   assign full    = count == (AW+1)'(DEPTH);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];
   always_ff @(posedge clk_25)
      if (do_push) mem[wr_ptr] <= din;
   always_ff @(posedge clk_25 or posedge rst)
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_ptr + AW'(do_push);
         rd_ptr <= rd_ptr + AW'(do_pop);
         count  <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
endmodule

// File: rtl/homography_responder.sv
// homography_responder: maps queries through an affine transform and returns source pixels in order.
// Optional HOMO_OOB_COLOR_EN adds oob_color, returned for out-of-bounds queries.
module homography_responder import homo_pkg::*; #(
   parameter int DEPTH  = 8,
   parameter int FRAC   = FRAC_DEF,
   parameter int COEF_W = COEF_W_DEF
) (
   input  logic                     clk_25,
   input  logic                     rst,
   input  logic                     start,
   input  logic [9:0]               query_x,
   input  logic [9:0]               query_y,
   input  logic signed [COEF_W-1:0] coef_a,
   input  logic signed [COEF_W-1:0] coef_b,
   input  logic signed [COEF_W-1:0] coef_c,
   input  logic signed [COEF_W-1:0] coef_d,
   input  logic signed [COEF_W-1:0] coef_e,
   input  logic signed [COEF_W-1:0] coef_f,
`ifdef HOMO_OOB_COLOR_EN
   input  logic [15:0]              oob_color,
`endif
   output logic                     mem_rd,
   output logic [ADDR_W-1:0]        mem_addr,
   input  logic [15:0]              mem_rdata,
   input  logic                     mem_rvalid,
   output logic [9:0]               return_x,
   output logic [9:0]               return_y,
   output logic [4:0]               r,
   output logic [5:0]               g,
   output logic [4:0]               b,
   output logic                     ready,
   output logic                     busy,
   output logic                     overflow
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = COEF_W + 11;
   localparam int SW = PW + 2;
   logic signed [PW-1:0] p_ax, p_by, p_dx, p_ey;
   logic signed [SW-1:0] sum_x, sum_y, sx, sy;
   logic [9:0] qx1, qy1;
   logic v1, oob, push, pop, full, empty;
   logic [ADDR_W-1:0] addr_n, ys;
   logic [AW:0] count;
   tag_t head;
   rgb565_t pix, fill;
`ifdef HOMO_OOB_COLOR_EN
   assign fill = rgb565_t'(oob_color);
`else
   assign fill = '0;
`endif
   always_ff @(posedge clk_25 or posedge rst)
      if (rst) begin
         v1   <= 1'b0;
         qx1  <= '0;
         qy1  <= '0;
         p_ax <= '0;
         p_by <= '0;
         p_dx <= '0;
         p_ey <= '0;
      end else begin
         v1   <= start;
         qx1  <= query_x;
         qy1  <= query_y;
         p_ax <= PW'(coef_a) * PW'($signed({1'b0, query_x}));
         p_by <= PW'(coef_b) * PW'($signed({1'b0, query_y}));
         p_dx <= PW'(coef_d) * PW'($signed({1'b0, query_x}));
         p_ey <= PW'(coef_e) * PW'($signed({1'b0, query_y}));
      end
   // full-width sums so the range check sees true out-of-frame values
   assign sum_x  = SW'(p_ax) + SW'(p_by) + SW'(coef_c);
   assign sum_y  = SW'(p_dx) + SW'(p_ey) + SW'(coef_f);
   assign sx     = sum_x >>> FRAC;
   assign sy     = sum_y >>> FRAC;
   assign oob    = sx[SW-1] || sx > SW'(H_RES-1) || sy[SW-1] || sy > SW'(V_RES-1);
   assign ys     = ADDR_W'(sy[9:0]);
   assign addr_n = oob ? '0 : (ys << 9) + (ys << 7) + ADDR_W'(sx[9:0]);
   assign pop    = mem_rvalid && !empty;
   assign push   = v1 && (!full || pop);
   assign pix    = head.oob ? fill : rgb565_t'(mem_rdata);
   assign busy   = count >= (AW+1)'(DEPTH-2);
   homo_tag_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_25(clk_25),
      .rst(rst),
      .push(push),
      .pop(pop),
      .din('{x: qx1, y: qy1, oob: oob}),
      .dout(head),
      .count(count),
      .full(full),
      .empty(empty)
   );
   always_ff @(posedge clk_25 or posedge rst)
      if (rst) begin
         mem_rd   <= 1'b0;
         mem_addr <= '0;
         ready    <= 1'b0;
         return_x <= '0;
         return_y <= '0;
         {r, g, b} <= '0;
         overflow <= 1'b0;
      end else begin
         mem_rd <= push;
         if (push) mem_addr <= addr_n;
         ready <= pop;
         if (pop) begin
            return_x  <= head.x;
            return_y  <= head.y;
            {r, g, b} <= pix;
         end
         if ((v1 && !push) || (mem_rvalid && empty)) overflow <= 1'b1;
      end
endmodule

// File: tb/tb_homography_responder.sv
// tb_homography_responder: scoreboard bench for homography_responder with a latency-programmable frame memory.
`timescale 1ns/1ps
module tb_homography_responder;
   import homo_pkg::*;
`ifdef HOMO_OOB_COLOR_EN
   localparam logic [15:0] OOB_RGB = 16'h07E0;
`else
   localparam logic [15:0] OOB_RGB = 16'h0000;
`endif
   typedef struct {
      logic [9:0]  x;
      logic [9:0]  y;
      logic [15:0] rgb;
   } resp_t;
   logic clk_25 = 0, rst = 1, start = 0;
   logic [9:0] query_x = 0, query_y = 0;
   logic signed [17:0] coef_a = 256, coef_b = 0, coef_c = 0, coef_d = 0, coef_e = 256, coef_f = 0;
   logic mem_rd, mem_rvalid = 0;
   logic [18:0] mem_addr;
   logic [15:0] mem_rdata = 0;
   logic [9:0] return_x, return_y;
   logic [4:0] r, b;
   logic [5:0] g;
   logic ready, busy, overflow;
`ifdef HOMO_OOB_COLOR_EN
   logic [15:0] oob_color = OOB_RGB;
`endif
   logic [18:0] exp_addr[$];
   resp_t exp_resp[$];
   logic [18:0] pend_addr[$];
   int pend_due[$];
   int rdy_cyc[$];
   int mem_lat = 2, cyc = 0, vec = 0, err = 0, rd_cnt = 0, rdy_cnt = 0;
   bit mem_hold = 0;

   homography_responder dut (
      .clk_25(clk_25), .rst(rst), .start(start), .query_x(query_x), .query_y(query_y),
      .coef_a(coef_a), .coef_b(coef_b), .coef_c(coef_c),
      .coef_d(coef_d), .coef_e(coef_e), .coef_f(coef_f),
`ifdef HOMO_OOB_COLOR_EN
      .oob_color(oob_color),
`endif
      .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
      .return_x(return_x), .return_y(return_y), .r(r), .g(g), .b(b),
      .ready(ready), .busy(busy), .overflow(overflow)
   );

   always #20 clk_25 = ~clk_25;

   function automatic logic [15:0] data_of(input logic [18:0] a);
      return (a == 19'd12810) ? 16'hF81F : (a[15:0] ^ 16'h5A3C) + {a[18:16], 13'd0};
   endfunction

   function automatic int floor256(input int s);
      return (s >= 0) ? s / 256 : -((-s + 255) / 256);
   endfunction

   // frame memory: answers each read in order after mem_lat cycles unless held
   always @(posedge clk_25) begin
      cyc++;
      #1;
      if (mem_rd) begin
         pend_addr.push_back(mem_addr);
         pend_due.push_back(cyc + mem_lat);
      end
      if (!mem_hold && pend_addr.size() > 0 && pend_due[0] <= cyc) begin
         mem_rvalid = 1;
         mem_rdata = data_of(pend_addr.pop_front());
         void'(pend_due.pop_front());
      end else begin
         mem_rvalid = 0;
         mem_rdata = 0;
      end
   end

   always @(negedge clk_25) begin
      logic [18:0] ea;
      resp_t er;
      if (mem_rd) begin
         rd_cnt++;
         vec++;
         if (exp_addr.size() == 0) begin
            err++;
            $display("FAIL unexpected_mem_rd addr=%0d expected no read", mem_addr);
         end else begin
            ea = exp_addr.pop_front();
            if (mem_addr !== ea) begin
               err++;
               $display("FAIL mem_addr got=%0d exp=%0d", mem_addr, ea);
            end
         end
      end
      if (ready) begin
         rdy_cnt++;
         rdy_cyc.push_back(cyc);
         vec++;
         if (exp_resp.size() == 0) begin
            err++;
            $display("FAIL unexpected_ready ret=(%0d,%0d) expected no response", return_x, return_y);
         end else begin
            er = exp_resp.pop_front();
            if ({return_x, return_y, r, g, b} !== {er.x, er.y, er.rgb}) begin
               err++;
               $display("FAIL response got=(%0d,%0d,%h) exp=(%0d,%0d,%h)",
                        return_x, return_y, {r, g, b}, er.x, er.y, er.rgb);
            end
         end
      end
   end

   task automatic set_coef(input int a, input int bb, input int c, input int d, input int e, input int f);
      coef_a = 18'(a); coef_b = 18'(bb); coef_c = 18'(c);
      coef_d = 18'(d); coef_e = 18'(e); coef_f = 18'(f);
   endtask

   task automatic send(input int x, input int y, input bit drop);
      int sx, sy;
      bit oob;
      logic [18:0] a;
      resp_t e;
      sx = floor256(int'(coef_a) * x + int'(coef_b) * y + int'(coef_c));
      sy = floor256(int'(coef_d) * x + int'(coef_e) * y + int'(coef_f));
      oob = sx < 0 || sx > 639 || sy < 0 || sy > 479;
      a = oob ? 19'd0 : 19'(sy * 640 + sx);
      e.x = x[9:0];
      e.y = y[9:0];
      e.rgb = oob ? OOB_RGB : data_of(a);
      if (!drop) begin
         exp_addr.push_back(a);
         exp_resp.push_back(e);
      end
      start = 1;
      query_x = x[9:0];
      query_y = y[9:0];
      @(posedge clk_25); #1;
      start = 0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (exp_resp.size() > 0 && n < 300) begin
         @(posedge clk_25); #1;
         n++;
      end
      vec++;
      if (exp_resp.size() != 0) begin
         err++;
         $display("FAIL %s_drain pending=%0d exp=0", name, exp_resp.size());
      end
      repeat (2) @(posedge clk_25);
      #1;
   endtask

   task automatic wait_ready(input string name);
      int n = 0;
      while (!ready && n < 30) begin
         @(posedge clk_25); #1;
         n++;
      end
      vec++;
      if (ready !== 1'b1) begin
         err++;
         $display("FAIL %s_ready_timeout got=%b exp=1", name, ready);
      end
   endtask

   task automatic test_reset;
      rst = 1;
      repeat (3) @(posedge clk_25);
      #1;
      vec++;
      if ({mem_rd, mem_addr, return_x, return_y, r, g, b, ready, busy, overflow} !== '0) begin
         err++;
         $display("FAIL reset_outputs got=%h exp=0",
                  {mem_rd, mem_addr, return_x, return_y, r, g, b, ready, busy, overflow});
      end
      rst = 0;
      @(posedge clk_25); #1;
   endtask

   task automatic test_identity;
      set_coef(256, 0, 0, 0, 256, 0);
      send(10, 20, 0);
      @(posedge clk_25); #1;
      vec++;
      if (mem_rd !== 1'b1 || mem_addr !== 19'd12810) begin
         err++;
         $display("FAIL identity_issue got rd=%b addr=%0d exp rd=1 addr=12810", mem_rd, mem_addr);
      end
      wait_ready("identity");
      vec++;
      if ({return_x, return_y, r, g, b} !== {10'd10, 10'd20, 5'd31, 6'd0, 5'd31}) begin
         err++;
         $display("FAIL identity_pixel got=(%0d,%0d,%0d,%0d,%0d) exp=(10,20,31,0,31)",
                  return_x, return_y, r, g, b);
      end
      send(639, 479, 0);
      send(640, 0, 0);
      send(0, 480, 0);
      send(123, 45, 0);
      wait_idle("identity");
   endtask

   task automatic test_translation;
      set_coef(256, 0, -25600, 0, 256, 0);
      send(50, 5, 0);
      @(posedge clk_25); #1;
      vec++;
      if (mem_rd !== 1'b1 || mem_addr !== 19'd0) begin
         err++;
         $display("FAIL translate_issue got rd=%b addr=%0d exp rd=1 addr=0", mem_rd, mem_addr);
      end
      wait_ready("translate");
      vec++;
      if ({return_x, return_y, r, g, b} !== {10'd50, 10'd5, OOB_RGB}) begin
         err++;
         $display("FAIL translate_oob got=(%0d,%0d,%h) exp=(50,5,%h)", return_x, return_y, {r, g, b}, OOB_RGB);
      end
      send(150, 5, 0);
      wait_idle("translate");
   endtask

   task automatic test_fraction;
      set_coef(384, 0, 0, 0, 256, 0);
      send(3, 0, 0);
      @(posedge clk_25); #1;
      vec++;
      if (mem_rd !== 1'b1 || mem_addr !== 19'd4) begin
         err++;
         $display("FAIL fraction_floor got rd=%b addr=%0d exp rd=1 addr=4", mem_rd, mem_addr);
      end
      wait_idle("fraction");
      set_coef(256, 0, -128, 0, 256, 0);
      send(0, 0, 0);
      send(1, 0, 0);
      send(640, 3, 0);
      wait_idle("neg_floor");
   endtask

   task automatic test_back_to_back;
      int r0;
      bit gap;
      set_coef(256, 0, 0, 0, 256, 0);
      mem_lat = 5;
      r0 = rdy_cnt;
      rdy_cyc.delete();
      for (int i = 0; i < 8; i++) send(i, 0, 0);
      wait_idle("b2b");
      vec++;
      if (rdy_cnt - r0 != 8) begin
         err++;
         $display("FAIL b2b_count got=%0d exp=8", rdy_cnt - r0);
      end
      gap = 0;
      for (int i = 1; i < rdy_cyc.size(); i++) if (rdy_cyc[i] != rdy_cyc[i-1] + 1) gap = 1;
      vec++;
      if (gap || rdy_cyc.size() != 8) begin
         err++;
         $display("FAIL b2b_consecutive got gap=%0d n=%0d exp gap=0 n=8", gap, rdy_cyc.size());
      end
      vec++;
      if (overflow !== 1'b0) begin
         err++;
         $display("FAIL b2b_overflow got=%b exp=0", overflow);
      end
   endtask

   task automatic test_overflow;
      int r0, q0;
      mem_hold = 1;
      r0 = rd_cnt;
      for (int i = 0; i < 9; i++) send(i, 1, i == 8);
      repeat (4) @(posedge clk_25);
      #1;
      vec++;
      if (rd_cnt - r0 != 8 || overflow !== 1'b1 || busy !== 1'b1) begin
         err++;
         $display("FAIL full_drop got rd=%0d ovf=%b busy=%b exp rd=8 ovf=1 busy=1", rd_cnt - r0, overflow, busy);
      end
      q0 = rdy_cnt;
      mem_hold = 0;
      wait_idle("full");
      repeat (10) @(posedge clk_25);
      #1;
      vec++;
      if (rdy_cnt - q0 != 8) begin
         err++;
         $display("FAIL full_responses got=%0d exp=8", rdy_cnt - q0);
      end
   endtask

   task automatic test_reset_flight;
      int q0;
      rst = 1;
      @(posedge clk_25); #1;
      rst = 0;
      vec++;
      if (overflow !== 1'b0) begin
         err++;
         $display("FAIL rst_clear_ovf got=%b exp=0", overflow);
      end
      mem_lat = 2;
      mem_hold = 1;
      for (int i = 0; i < 4; i++) send(i, 2, 0);
      repeat (4) @(posedge clk_25);
      #1;
      rst = 1;
      exp_resp.delete();
      exp_addr.delete();
      repeat (2) @(posedge clk_25);
      #1;
      rst = 0;
      q0 = rdy_cnt;
      mem_hold = 0;
      repeat (15) @(posedge clk_25);
      #1;
      vec++;
      if (rdy_cnt != q0 || overflow !== 1'b1) begin
         err++;
         $display("FAIL stale_resp got ready=%0d ovf=%b exp ready=0 ovf=1", rdy_cnt - q0, overflow);
      end
      send(7, 7, 0);
      wait_idle("post_reset");
      vec++;
      if (rdy_cnt - q0 != 1) begin
         err++;
         $display("FAIL post_reset_query got=%0d exp=1", rdy_cnt - q0);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_identity();
      test_translation();
      test_fraction();
      test_back_to_back();
      test_overflow();
      test_reset_flight();
      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end
endmodule

// File: doc/homography_responder.md
Name: homography_responder

Overview:
- Serves the homography query side of the display path.
- Accepts one (query_x, query_y) per cycle on start and maps it through a fixed-point affine transform onto the 640x480 source frame.
- Reads the RGB565 source pixel from frame memory and returns it in order on return_x/return_y/r/g/b with a one-cycle ready pulse.
- Sits between the sync controller's query port and the frame SRAM arbiter.

Parameters:
- DEPTH, 8, outstanding-read tag FIFO entries (power of 2, 4..32)
- FRAC, 8, fractional bits of the coefficients
- COEF_W, 18, signed coefficient width

Ports:
- clk_25  in  1  pixel clock
- rst  in  1  asynchronous active-high reset
- start  in  1  query valid this cycle
- query_x  in  10  destination x
- query_y  in  10  destination y
- coef_a, coef_b, coef_c  in  COEF_W each  signed; x' = a*x + b*y + c
- coef_d, coef_e, coef_f  in  COEF_W each  signed; y' = d*x + e*y + f
- mem_rd  out  1  read strobe
- mem_addr  out  19  y'*640 + x'
- mem_rdata  in  16  RGB565 {r[15:11], g[10:5], b[4:0]}
- mem_rvalid  in  1  read data valid; in order, one per mem_rd, latency >= 1
- return_x  out  10  echoed query_x
- return_y  out  10  echoed query_y
- r  out  5
- g  out  6
- b  out  5
- ready  out  1  one-cycle response strobe
- busy  out  1  tag FIFO count >= DEPTH-2
- overflow  out  1  sticky: a query was dropped

Behaviour:
- Reset: every output is 0; FIFO is emptied; pipeline valids are cleared; overflow is cleared. Coefficients are static while start traffic flows, so they are not registered.
- Stage 1 (cycle after start): register the four products a*x, b*y, d*x, e*y (x, y zero-extended) and the query coordinates.
- Stage 2:
  - sx = (a*x + b*y + c) >>> FRAC, arithmetic shift, i.e. floor.
  - sy is formed the same way from d, e, f.
  - Sums are computed at full width, with no saturation before the range check.
  - oob = sx < 0 or sx > 639 or sy < 0 or sy > 479.
- Issue: the cycle after stage 2, mem_rd = 1 and mem_addr = oob ? 0 : sy*640 + sx, using the shift-add (sy<<9) + (sy<<7) + sx. The tag {query_x, query_y, oob} is pushed into the FIFO in the same cycle.
- Every accepted query issues exactly one read, including oob ones. Memory responses therefore map 1:1 onto FIFO entries.
- Accept check is done at stage-2 exit:
  - If the FIFO is full and no pop occurs that cycle, the query is dropped: no mem_rd, overflow <= 1.
  - A push and a pop in the same cycle when full is accepted.
- Return:
  - On mem_rvalid with the FIFO non-empty, pop the head. The next cycle drives ready = 1, return_x/return_y = tag, and {r,g,b} = oob ? 0 : mem_rdata fields.
  - With no new response, ready returns to 0 and the data outputs hold their values.
- mem_rvalid with the FIFO empty (stale read after reset) is ignored and sets overflow.
- Latency: start to mem_rd is 2 cycles. mem_rvalid to ready is 1 cycle.
- Throughput: one query per cycle, sustained while memory keeps pace.
- Ordering is strictly first in, first out. start can be asserted on consecutive cycles with no gap.
- rst mid-flight discards all in-flight queries; no ready is produced for them.

Optional Feature:
- Macro: HOMO_OOB_COLOR_EN.
- When defined, adds input oob_color[15:0]. Out-of-bounds responses return oob_color split as RGB565.
- When undefined, the port is absent and out-of-bounds responses return r = g = b = 0.

Decomposition:
- Package homo_pkg holds:
  - H_RES = 640, V_RES = 480
  - ADDR_W = 19
  - the rgb565_t struct {r5, g6, b5}
  - the tag_t struct {x10, y10, oob}
  - the default FRAC and COEF_W
- Sub-module homo_tag_fifo: synchronous FIFO of tag_t, DEPTH entries, exposing count, full and empty, with simultaneous push/pop supported.

Test Plan:
- Identity transform (a = e = 256, the rest 0), query (10,20): mem_addr = 12810 two cycles after start. mem_rdata = 16'hF81F gives ready with return (10,20), r = 31, g = 0, b = 31.
- Translation c = -25600 (-100.0), query (50,5): sx = -50 is oob, so mem_addr = 0. The response has r = g = b = 0 and return (50,5).
- Fractional floor, a = 384 (1.5), e = 256, query (3,0): mem_addr = 4.
- 8 back-to-back starts, queries (0,0)..(7,0), memory latency 5: 8 consecutive ready pulses in query order with matching return_x. overflow stays 0.
- DEPTH = 8 with mem_rvalid held low, 9 starts: 8 mem_rd issued, overflow = 1, busy = 1. Releasing memory then yields exactly 8 responses.
- Reset asserted with 4 reads outstanding, followed by 4 stale mem_rvalid: no ready, overflow = 1. A query after reset completes normally.
